// File: rtl/seg7_pkg.sv
// Shared constants for the BCD counter and its active-low 7-segment decode.
// Segment order is {a,b,c,d,e,f,g,dp}; dp is always off.
package seg7_pkg;

   localparam logic [7:0] SEG_0     = 8'b00000011;
   localparam logic [7:0] SEG_1     = 8'b10011111;
   localparam logic [7:0] SEG_2     = 8'b00100101;
   localparam logic [7:0] SEG_3     = 8'b00001101;
   localparam logic [7:0] SEG_4     = 8'b10011001;
   localparam logic [7:0] SEG_5     = 8'b01001001;
   localparam logic [7:0] SEG_6     = 8'b01000001;
   localparam logic [7:0] SEG_7     = 8'b00011111;
   localparam logic [7:0] SEG_8     = 8'b00000001;
   localparam logic [7:0] SEG_9     = 8'b00001001;
   localparam logic [7:0] SEG_BLANK = 8'hFF;
   localparam logic [3:0] BCD_MAX   = 4'd9;

   function automatic logic [7:0] seg_decode(input logic [3:0] v);
      logic [7:0] s;
      case (v)
         4'd0:    s = SEG_0;
         4'd1:    s = SEG_1;
         4'd2:    s = SEG_2;
         4'd3:    s = SEG_3;
         4'd4:    s = SEG_4;
         4'd5:    s = SEG_5;
         4'd6:    s = SEG_6;
         4'd7:    s = SEG_7;
         4'd8:    s = SEG_8;
         4'd9:    s = SEG_9;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the counter chain: increment or decrement when step_i is set,
// propagating carry (up) or borrow (down) to the next digit through step_o.
module bcd_digit
   import seg7_pkg::*;
(
   input  logic [3:0] val_i,
   input  logic       step_i,
   input  logic       up_i,
   output logic [3:0] val_o,
   output logic       step_o
);

   always_comb begin
      val_o  = val_i;
      step_o = 1'b0;
      if (step_i) begin
         if (up_i) begin
            if (val_i == BCD_MAX) begin
               val_o  = 4'd0;
               step_o = 1'b1;
            end else begin
               val_o = val_i + 4'd1;
            end
         end else begin
            if (val_i == 4'd0) begin
               val_o  = BCD_MAX;
               step_o = 1'b1;
            end else begin
               val_o = val_i - 4'd1;
            end
         end
      end
   end

endmodule

// File: rtl/bcd_updown_scan_counter.sv
// Multi-digit BCD up/down counter with parallel load, tick-enabled counting and a
// time-multiplexed common-anode 7-segment driver with optional leading-zero blanking.
module bcd_updown_scan_counter
   import seg7_pkg::*;
#(
   parameter int unsigned DIGITS   = 4,
   parameter int unsigned TICK_DIV = 25000000,
   parameter int unsigned SCAN_DIV = 50000,
   parameter int unsigned BLANK_LZ = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  en,
   input  logic                  up,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_val,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  tick,
   output logic                  wrap,
   output logic [DIGITS-1:0]     an,
   output logic [7:0]            seg
);

   localparam int unsigned TW = $clog2(TICK_DIV);
   localparam int unsigned SW = $clog2(SCAN_DIV);
   localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [DIGITS-1:0] AN_RESET = ~DIGITS'(1);

   logic [TW-1:0]         tdiv_q, tdiv_d;
   logic                  tick_q, tick_d;
   logic [4*DIGITS-1:0]   bcd_q, bcd_d;
   logic                  wrap_q, wrap_d;
   logic [SW-1:0]         sdiv_q, sdiv_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [DIGITS-1:0]     an_q, an_d;
   logic [7:0]            seg_q, seg_d;

   logic [4*DIGITS-1:0]   cnt_next;
   logic [4*DIGITS-1:0]   ld_clamped;
   logic [DIGITS:0]       step;
   logic [DIGITS-1:0]     lz;
   logic                  zero_above;
   logic [3:0]            cur_digit;
   logic                  blank;

   // The chain always computes "count by one"; the result is only taken on tick & en.
   assign step[0] = 1'b1;

   for (genvar i = 0; i < DIGITS; i++) begin : g_digit
      bcd_digit u_digit (
         .val_i  (bcd_q[4*i +: 4]),
         .step_i (step[i]),
         .up_i   (up),
         .val_o  (cnt_next[4*i +: 4]),
         .step_o (step[i+1])
      );
   end

   always_comb begin
      tdiv_d = (tdiv_q == TW'(TICK_DIV - 1)) ? '0 : tdiv_q + TW'(1);
      tick_d = (tdiv_q == TW'(TICK_DIV - 1));

      ld_clamped = '0;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (load_val[4*i +: 4] > BCD_MAX) begin
            ld_clamped[4*i +: 4] = BCD_MAX;
         end else begin
            ld_clamped[4*i +: 4] = load_val[4*i +: 4];
         end
      end

      bcd_d  = bcd_q;
      wrap_d = 1'b0;
      if (load) begin
         bcd_d = ld_clamped;
      end else if (tick_q && en) begin
         bcd_d  = cnt_next;
         wrap_d = step[DIGITS];
      end

      sdiv_d = (sdiv_q == SW'(SCAN_DIV - 1)) ? '0 : sdiv_q + SW'(1);
      idx_d  = idx_q;
      if (sdiv_q == SW'(SCAN_DIV - 1)) begin
         idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
      end
   end

   // lz[i] is set when digit i and every digit above it are zero.
   always_comb begin
      lz         = '0;
      zero_above = 1'b1;
      for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
         zero_above = zero_above && (bcd_q[4*i +: 4] == 4'd0);
         lz[i]      = zero_above;
      end

      cur_digit = '0;
      blank     = 1'b0;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (idx_q == IW'(i)) begin
            cur_digit = bcd_q[4*i +: 4];
            blank     = (BLANK_LZ != 0) && (i != 0) && lz[i];
         end
      end

      an_d  = '1;
      seg_d = SEG_BLANK;
      if (!blank) begin
         an_d  = ~(DIGITS'(1) << idx_q);
         seg_d = seg_decode(cur_digit);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         tdiv_q <= '0;
         tick_q <= 1'b0;
         bcd_q  <= '0;
         wrap_q <= 1'b0;
         sdiv_q <= '0;
         idx_q  <= '0;
         an_q   <= AN_RESET;
         seg_q  <= SEG_0;
      end else begin
         tdiv_q <= tdiv_d;
         tick_q <= tick_d;
         bcd_q  <= bcd_d;
         wrap_q <= wrap_d;
         sdiv_q <= sdiv_d;
         idx_q  <= idx_d;
         an_q   <= an_d;
         seg_q  <= seg_d;
      end
   end

   assign bcd  = bcd_q;
   assign tick = tick_q;
   assign wrap = wrap_q;
   assign an   = an_q;
   assign seg  = seg_q;

endmodule

// File: tb/tb_bcd_updown_scan_counter.sv
// Scoreboard bench: stimulus queues expected count updates and display samples,
// a negedge monitor pops and compares them as the DUTs present new outputs.
module tb_bcd_updown_scan_counter;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        en = 1'b0;
   logic        up = 1'b1;
   logic        load = 1'b0;
   logic [15:0] load_val = '0;

   logic [15:0] bcd, bcd_nb;
   logic        tick, tick_nb, wrap, wrap_nb;
   logic [3:0]  an, an_nb;
   logic [7:0]  seg, seg_nb;

   bcd_updown_scan_counter #(
      .DIGITS   (4),
      .TICK_DIV (4),
      .SCAN_DIV (3),
      .BLANK_LZ (1)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .en       (en),
      .up       (up),
      .load     (load),
      .load_val (load_val),
      .bcd      (bcd),
      .tick     (tick),
      .wrap     (wrap),
      .an       (an),
      .seg      (seg)
   );

   bcd_updown_scan_counter #(
      .DIGITS   (4),
      .TICK_DIV (4),
      .SCAN_DIV (3),
      .BLANK_LZ (0)
   ) dut_nb (
      .clk      (clk),
      .reset    (reset),
      .en       (en),
      .up       (up),
      .load     (load),
      .load_val (load_val),
      .bcd      (bcd_nb),
      .tick     (tick_nb),
      .wrap     (wrap_nb),
      .an       (an_nb),
      .seg      (seg_nb)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [15:0] bcd;
      logic        wrap;
   } cnt_exp_t;

   cnt_exp_t    cnt_q[$];
   logic [23:0] disp_q[$];   // {an, seg, an_nb, seg_nb}

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [15:0] bcd_prev;
   bit          mon_en   = 1'b0;
   bit          tick_mon = 1'b0;
   int          tgap     = 0;
   cnt_exp_t    mon_c;
   logic [23:0] mon_d;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   task automatic push_cnt(input logic [15:0] b, input logic w);
      cnt_exp_t e;
      e.bcd  = b;
      e.wrap = w;
      cnt_q.push_back(e);
   endtask

   task automatic wait_cnt(input int budget);
      int n = 0;
      while (cnt_q.size() != 0 && n < budget) begin
         @(posedge clk);
         n++;
      end
      #2;
      check("cnt_drain", 64'(cnt_q.size()), 64'd0);
      cnt_q.delete();
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         if (bcd !== bcd_prev) begin
            if (cnt_q.size() == 0) begin
               check("unexpected_bcd_change", 64'(bcd), 64'(bcd_prev));
            end else begin
               mon_c = cnt_q.pop_front();
               check("bcd_update", {bcd, wrap, bcd_nb, wrap_nb},
                     {mon_c.bcd, mon_c.wrap, mon_c.bcd, mon_c.wrap});
            end
         end else begin
            check("wrap_idle", 64'({wrap, wrap_nb}), 64'd0);
         end
      end
      if (tick_mon) begin
         tgap++;
         if (tick) begin
            check("tick_period", 64'(tgap), 64'd4);
            tgap = 0;
         end
      end
      if (disp_q.size() > 0) begin
         mon_d = disp_q.pop_front();
         check("scan", 64'({an, seg, an_nb, seg_nb}), 64'(mon_d));
      end
      bcd_prev = bcd;
   end

   initial begin
      logic [11:0] slot_blank [4];
      logic [11:0] slot_nb [4];
      int          n;

      // 1: reset held for three edges
      repeat (3) @(posedge clk);
      #2 reset = 1'b1;
      @(negedge clk);
      #1;
      check("reset_bcd", 64'({bcd, bcd_nb}), 64'd0);
      check("reset_an", 64'({an, an_nb}), 64'({4'b1110, 4'b1110}));
      check("reset_seg", 64'({seg, seg_nb}), 64'({8'b00000011, 8'b00000011}));
      check("reset_tick", 64'({tick, tick_nb}), 64'd0);
      check("reset_wrap", 64'({wrap, wrap_nb}), 64'd0);

      // 2: ten ticks up, then hold with en=0
      mon_en   = 1'b1;
      tick_mon = 1'b1;
      tgap     = 0;
      en       = 1'b1;
      up       = 1'b1;
      for (int i = 1; i <= 9; i++) push_cnt(16'(i), 1'b0);
      push_cnt(16'h0010, 1'b0);
      wait_cnt(60);
      en = 1'b0;
      repeat (12) @(posedge clk);
      #2 check("hold_en0", 64'(bcd), 64'h0010);

      // 3: wrap up from 9999, wrap down from 0000
      load = 1'b1;
      load_val = 16'h9999;
      push_cnt(16'h9999, 1'b0);
      @(posedge clk);
      #2 load = 1'b0;
      en = 1'b1;
      up = 1'b1;
      push_cnt(16'h0000, 1'b1);
      wait_cnt(20);
      en = 1'b0;
      load = 1'b1;
      load_val = 16'h0000;
      @(posedge clk);
      #2 load = 1'b0;
      up = 1'b0;
      en = 1'b1;
      push_cnt(16'h9999, 1'b1);
      wait_cnt(20);
      en = 1'b0;

      // 4: clamped load, then load on the tick cycle
      load = 1'b1;
      load_val = 16'h1A3F;
      push_cnt(16'h1939, 1'b0);
      @(posedge clk);
      #2 load = 1'b0;
      wait_cnt(5);
      n = 0;
      do begin
         @(posedge clk);
         #2 n++;
      end while (!tick && n < 10);
      check("tick_seen", 64'(tick), 64'd1);
      load = 1'b1;
      load_val = 16'h2468;
      en = 1'b1;
      up = 1'b1;
      push_cnt(16'h2468, 1'b0);
      @(posedge clk);
      #2 load = 1'b0;
      en = 1'b0;
      wait_cnt(5);
      repeat (8) @(posedge clk);
      #2 check("load_beats_tick", 64'(bcd), 64'h2468);

      // 5: scan of 0042 with and without leading-zero blanking
      tick_mon = 1'b0;
      slot_blank[0] = {4'b1110, 8'b00100101};
      slot_blank[1] = {4'b1101, 8'b10011001};
      slot_blank[2] = {4'b1111, 8'b11111111};
      slot_blank[3] = {4'b1111, 8'b11111111};
      slot_nb[0]    = {4'b1110, 8'b00100101};
      slot_nb[1]    = {4'b1101, 8'b10011001};
      slot_nb[2]    = {4'b1011, 8'b00000011};
      slot_nb[3]    = {4'b0111, 8'b00000011};
      @(posedge clk);
      #2 reset = 1'b0;
      push_cnt(16'h0000, 1'b0);
      @(posedge clk);
      #2 reset = 1'b1;
      load = 1'b1;
      load_val = 16'h0042;
      push_cnt(16'h0042, 1'b0);
      for (int k = 0; k < 16; k++) begin
         if (k < 2) disp_q.push_back({4'b1110, 8'b00000011, 4'b1110, 8'b00000011});
         else disp_q.push_back({slot_blank[((k - 1) / 3) % 4], slot_nb[((k - 1) / 3) % 4]});
      end
      @(posedge clk);
      #2 load = 1'b0;
      n = 0;
      while (disp_q.size() != 0 && n < 30) begin
         @(posedge clk);
         n++;
      end
      #2 check("scan_drain", 64'(disp_q.size()), 64'd0);
      disp_q.delete();
      wait_cnt(2);

      // 6: reset mid-count at 0057 while digit 2 is being scanned
      load = 1'b1;
      load_val = 16'h0056;
      push_cnt(16'h0056, 1'b0);
      @(posedge clk);
      #2 load = 1'b0;
      en = 1'b1;
      up = 1'b1;
      push_cnt(16'h0057, 1'b0);
      wait_cnt(20);
      en = 1'b0;
      n = 0;
      while (an_nb !== 4'b1011 && n < 20) begin
         @(posedge clk);
         #2 n++;
      end
      check("scan_idx2_seen", 64'(an_nb), 64'b1011);
      reset = 1'b0;
      push_cnt(16'h0000, 1'b0);
      @(posedge clk);
      #2 reset = 1'b1;
      @(negedge clk);
      #1;
      check("midrst_bcd", 64'({bcd, bcd_nb}), 64'd0);
      check("midrst_an", 64'({an, an_nb}), 64'({4'b1110, 4'b1110}));
      check("midrst_seg", 64'({seg, seg_nb}), 64'({8'b00000011, 8'b00000011}));
      check("midrst_pulses", 64'({tick, wrap, tick_nb, wrap_nb}), 64'd0);

      repeat (6) @(posedge clk);
      #2 check("final_queue_empty", 64'(cnt_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
